// File: rtl/fork_join_scheduler.sv
// Fork/join scheduler: launches up to NUM_TASKS timed task slots and releases the continuation per join mode.
// Latency: accepted on the start edge; a slot of duration d completes d-1 cycles after launch (0 counts as 1).
// Backpressure: start is ignored while busy or while abort is high; abort kills the whole fork at the next edge.
module fork_join_scheduler #(
   parameter int NUM_TASKS = 4,
   parameter int CNT_W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [1:0]                 mode,
   input  logic [NUM_TASKS-1:0]       en,
   input  logic [NUM_TASKS*CNT_W-1:0] dur,
   input  logic                       abort,
   output logic                       busy,
   output logic [NUM_TASKS-1:0]       task_active,
   output logic [NUM_TASKS-1:0]       task_done,
   output logic                       join_done,
   output logic                       all_done,
   output logic [15:0]                elapsed
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_mode;
   logic [NUM_TASKS-1:0] r_active;
   logic [CNT_W-1:0]     r_cnt [NUM_TASKS];
   logic                 r_jn_arm;
   logic                 r_jn_fire;
   logic [15:0]          r_elapsed;

   logic                 w_accept;
   logic [NUM_TASKS-1:0] w_fin;
   logic                 w_last;
   logic                 w_any;
   logic                 w_none;

   assign w_accept = (r_state == S_IDLE) && start && !abort && (en != '0);
   assign w_any    = (r_mode == 2'b01);
   assign w_none   = (r_mode == 2'b10);

   // A slot finishes in the cycle its counter reads 1 (its last active cycle).
   always_comb begin
      w_fin = '0;
      for (int i = 0; i < NUM_TASKS; i++) begin
         w_fin[i] = r_active[i] && (r_cnt[i] == CNT_W'(1));
      end
   end

   // Last running slot(s) finish when nothing active survives this cycle.
   assign w_last = (w_fin != '0) && ((r_active & ~w_fin) == '0);

   assign busy        = (r_state != S_IDLE);
   assign task_active = r_active;
   assign task_done   = abort ? '0 : w_fin;
   assign all_done    = busy && !abort && w_last;
   // join_none releases from a delayed pulse; join_any/join release from RUN only, so once per fork.
   assign join_done   = r_jn_fire ||
                        ((r_state == S_RUN) && !abort && (w_any ? (w_fin != '0) : w_last));
   assign elapsed     = r_elapsed;

   // Next-state: RUN holds until the continuation is released, DRAIN until every slot is done.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (mode == 2'b10) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (abort || w_last) begin
               w_state_nxt = S_IDLE;
            end else if (w_any && (w_fin != '0)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort || w_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Per-slot launch, countdown and retirement; abort drops every slot at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= '0;
         r_mode   <= 2'b00;
         for (int i = 0; i < NUM_TASKS; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (w_accept) begin
         r_active <= en;
         r_mode   <= mode;
         for (int i = 0; i < NUM_TASKS; i++) begin
            r_cnt[i] <= (dur[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : dur[i*CNT_W +: CNT_W];
         end
      end else if (abort) begin
         r_active <= '0;
         for (int i = 0; i < NUM_TASKS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TASKS; i++) begin
            if (r_active[i]) begin
               if (r_cnt[i] == CNT_W'(1)) begin
                  r_active[i] <= 1'b0;
               end else begin
                  r_cnt[i] <= r_cnt[i] - CNT_W'(1);
               end
            end
         end
      end
   end

   // join_none release: armed at launch, fires one cycle later unless the fork was aborted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_jn_arm  <= 1'b0;
         r_jn_fire <= 1'b0;
      end else begin
         r_jn_arm  <= w_accept && (mode == 2'b10);
         r_jn_fire <= r_jn_arm && !abort;
      end
   end

   // Elapsed: 1 in the launch cycle, counts while the fork stays busy, holds once it ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_elapsed <= '0;
      end else if (w_accept) begin
         r_elapsed <= 16'd1;
      end else if (busy && (w_state_nxt != S_IDLE) && (r_elapsed != 16'hFFFF)) begin
         r_elapsed <= r_elapsed + 16'd1;
      end
   end

endmodule

// File: tb/tb_fork_join_scheduler.sv
// Bench for fork_join_scheduler: table of forks with hand-derived event cycles, expanded
// into per-cycle expectations queued at launch and popped as the DUT runs, plus
// hand-written sequences for ignored start, abort and mid-fork reset.
module tb_fork_join_scheduler;
   localparam int NT = 4;
   localparam int CW = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [1:0]       mode;
   logic [NT-1:0]    en;
   logic [NT*CW-1:0] dur;
   logic             abort;
   logic             busy;
   logic [NT-1:0]    task_active;
   logic [NT-1:0]    task_done;
   logic             join_done;
   logic             all_done;
   logic [15:0]      elapsed;

   int n_chk  = 0;
   int n_pass = 0;

   // td: cycle offset (from launch cycle 0) of each slot's task_done; jd/ad: join_done/all_done offsets.
   typedef struct packed {
      logic [1:0]  mode;
      logic [3:0]  en;
      logic [31:0] dur;
      logic [31:0] td;
      logic [7:0]  jd;
      logic [7:0]  ad;
   } vec_t;

   typedef struct packed {
      logic        busy;
      logic [3:0]  act;
      logic [3:0]  done;
      logic        jd;
      logic        ad;
      logic [15:0] el;
   } exp_t;

   vec_t vt [8];
   exp_t q [$];

   fork_join_scheduler #(.NUM_TASKS(NT), .CNT_W(CW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mode        (mode),
      .en          (en),
      .dur         (dur),
      .abort       (abort),
      .busy        (busy),
      .task_active (task_active),
      .task_done   (task_done),
      .join_done   (join_done),
      .all_done    (all_done),
      .elapsed     (elapsed)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic [1:0] m, input logic [3:0] e,
                                input logic [7:0] d3, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0,
                                input logic [7:0] t3, input logic [7:0] t2,
                                input logic [7:0] t1, input logic [7:0] t0,
                                input logic [7:0] j, input logic [7:0] a);
      vec_t v;
      v.mode = m;
      v.en   = e;
      v.dur  = {d3, d2, d1, d0};
      v.td   = {t3, t2, t1, t0};
      v.jd   = j;
      v.ad   = a;
      return v;
   endfunction

   function automatic exp_t obs();
      exp_t o;
      o.busy = busy;
      o.act  = task_active;
      o.done = task_done;
      o.jd   = join_done;
      o.ad   = all_done;
      o.el   = elapsed;
      return o;
   endfunction

   function automatic exp_t mke(input logic b, input logic [3:0] a, input logic [3:0] d,
                                input logic j, input logic al, input logic [15:0] el);
      exp_t o;
      o.busy = b;
      o.act  = a;
      o.done = d;
      o.jd   = j;
      o.ad   = al;
      o.el   = el;
      return o;
   endfunction

   task automatic check(input string name, input exp_t got, input exp_t want);
      n_chk++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got busy=%b act=%b done=%b join=%b all=%b el=%0d, want busy=%b act=%b done=%b join=%b all=%b el=%0d",
                  name, got.busy, got.act, got.done, got.jd, got.ad, got.el,
                  want.busy, want.act, want.done, want.jd, want.ad, want.el);
      end
   endtask

   // Launch one fork, queue its expected per-cycle outputs, then compare cycle by cycle.
   // kstart >= 0 pulses an extra start in that cycle, which must be ignored.
   task automatic run_vec(input vec_t v, input int kstart, input string nm);
      int   last;
      int   ad;
      int   jd;
      int   t;
      exp_t e;
      exp_t got;
      ad   = int'(v.ad);
      jd   = int'(v.jd);
      last = ((jd > ad) ? jd : ad) + 2;
      @(negedge clk);
      mode  = v.mode;
      en    = v.en;
      dur   = v.dur;
      start = 1'b1;
      for (int k = 0; k <= last; k++) begin
         e.busy = (k <= ad);
         for (int i = 0; i < NT; i++) begin
            t         = int'(v.td[i*8 +: 8]);
            e.act[i]  = v.en[i] && (k <= t);
            e.done[i] = v.en[i] && (k == t);
         end
         e.jd = (k == jd);
         e.ad = (k == ad);
         e.el = (k <= ad) ? 16'(k + 1) : 16'(ad + 1);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k <= last; k++) begin
         got = obs();
         e   = q.pop_front();
         check($sformatf("%s cyc%0d", nm, k), got, e);
         if (k == kstart) begin
            start = 1'b1;
            mode  = 2'b00;
            en    = 4'b1111;
            dur   = {4{8'd2}};
         end else if (k == kstart + 1) begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Vector table: mode, en, dur3..dur0, td3..td0, join offset, all offset.
      vt[0] = mkv(2'b00, 4'b0011, 8'd0, 8'd0, 8'd5, 8'd3, 8'hFF, 8'hFF, 8'd4, 8'd2, 8'd4, 8'd4);
      vt[1] = mkv(2'b01, 4'b0011, 8'd0, 8'd0, 8'd5, 8'd3, 8'hFF, 8'hFF, 8'd4, 8'd2, 8'd2, 8'd4);
      vt[2] = mkv(2'b10, 4'b0001, 8'd0, 8'd0, 8'd0, 8'd1, 8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd1, 8'd0);
      vt[3] = mkv(2'b00, 4'b1111, 8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
      vt[4] = mkv(2'b11, 4'b0101, 8'd0, 8'd2, 8'd0, 8'd0, 8'hFF, 8'd1, 8'hFF, 8'd0, 8'd1, 8'd1);
      vt[5] = mkv(2'b01, 4'b1010, 8'd2, 8'd0, 8'd6, 8'd0, 8'd1, 8'hFF, 8'd5, 8'hFF, 8'd1, 8'd5);
      vt[6] = mkv(2'b10, 4'b1100, 8'd3, 8'd3, 8'd0, 8'd0, 8'd2, 8'd2, 8'hFF, 8'hFF, 8'd1, 8'd2);
      vt[7] = mkv(2'b01, 4'b0011, 8'd0, 8'd0, 8'd2, 8'd2, 8'hFF, 8'hFF, 8'd1, 8'd1, 8'd1, 8'd1);

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      mode  = 2'b00;
      en    = '0;
      dur   = '0;
      #12;
      check("reset", obs(), mke(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'd0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 8; n++) begin
         run_vec(vt[n], (n == 3) ? 2 : -1, $sformatf("vec%0d", n));
      end

      // start with an empty mask: no response, elapsed holds the last fork's value.
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b00;
      en    = 4'b0000;
      dur   = {4{8'd3}};
      @(posedge clk);
      #1;
      start = 1'b0;
      check("empty_en", obs(), mke(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'd2));

      // abort in IDLE blocks start.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      en    = 4'b0001;
      dur   = {4{8'd5}};
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort", obs(), mke(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'd2));

      // abort in the cycle slot 0 would finish: its pulse is suppressed and the fork dies.
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b00;
      en    = 4'b0011;
      dur   = {8'd0, 8'd0, 8'd10, 8'd2};
      @(posedge clk);
      #1;
      start = 1'b0;
      check("abort_launch", obs(), mke(1'b1, 4'b0011, 4'b0, 1'b0, 1'b0, 16'd1));
      @(posedge clk);
      #1;
      abort = 1'b1;
      #1;
      check("abort_suppress", obs(), mke(1'b1, 4'b0011, 4'b0, 1'b0, 1'b0, 16'd2));
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_cleared", obs(), mke(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'd2));
      run_vec(vt[2], -1, "post_abort");

      // reset mid-fork clears outputs without a clock edge.
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b00;
      en    = 4'b0001;
      dur   = {4{8'd10}};
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", obs(), mke(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'd0));
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(mkv(2'b00, 4'b0001, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd0),
              -1, "post_reset_dur0");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
